// File: rtl/cpu_imem_loader.sv
// cpu_imem_loader: byte-stream program loader in front of the core's instruction RAM.
// A load is a 2-byte little-endian word count N followed by N little-endian 32-bit words.
// The RAM is written only while the core is held (running=0). The fetch port is a
// combinational read that returns NOP_WORD whenever the core is not running.
module cpu_imem_loader #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              running,
  input  logic [15:0]       pc,
  output logic [31:0]       pc_instr,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int          DEPTH   = 1 << ADDR_W;
  // Largest legal word count, widened so that N == 2^ADDR_W can still be compared.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    RUN,
    ERR
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [7:0]      r_len_lo;
  logic [7:0]      r_len_hi;
  logic [ADDR_W:0] r_word_cnt;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_asm;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_in_data;
  logic            w_word_done;
  logic            w_hdr_bad;
  logic            w_last_word;
  logic            w_pc_oor;
  logic [15:0]     w_hdr_len;
  logic [16:0]     w_cnt_inc;
  logic [13:0]     w_pc_word;
  logic [1:0]      w_unused_pc_lsb;

  // The loader only takes bytes while parsing a header or collecting data.
  assign byte_ready = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
  assign running    = (r_state == RUN);
  assign load_err   = (r_state == ERR);
  assign word_cnt   = r_word_cnt;

  // A byte that collides with load_start belongs to the aborted load and is dropped.
  assign w_accept    = byte_valid && byte_ready && !load_start;
  assign w_in_data   = w_accept && (r_state == DATA);
  assign w_word_done = w_in_data && (r_byte_idx == 2'd3);

  // Header length as it will be once the high byte on the bus is latched.
  assign w_hdr_len = {byte_data, r_len_lo};
  assign w_hdr_bad = (w_hdr_len == 16'd0) || ({1'b0, w_hdr_len} > DEPTH_W);

  // The word being completed now is the last one when its 1-based count equals N.
  assign w_cnt_inc   = 17'(r_word_cnt) + 17'd1;
  assign w_last_word = (w_cnt_inc == {1'b0, r_len_hi, r_len_lo});

  // Fetch side: byte address -> word address, byte offset ignored.
  assign w_pc_word       = pc[15:2];
  assign w_unused_pc_lsb = pc[1:0];
  assign w_pc_oor        = (w_pc_word >> ADDR_W) != 14'd0;
  assign pc_instr        = (running && !w_pc_oor) ? r_mem[w_pc_word[ADDR_W-1:0]] : NOP_WORD;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: load_start restarts from any state, otherwise follow the byte stream.
  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      w_state_nxt = LEN_LO;
    end else begin
      case (r_state)
        LEN_LO: begin
          if (w_accept) w_state_nxt = LEN_HI;
        end
        LEN_HI: begin
          if (w_accept) w_state_nxt = w_hdr_bad ? ERR : DATA;
        end
        DATA: begin
          if (w_word_done && w_last_word) w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Header latches, word counter and byte index; cleared by load_start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_lo   <= 8'd0;
      r_len_hi   <= 8'd0;
      r_word_cnt <= '0;
      r_byte_idx <= 2'd0;
    end else if (load_start) begin
      r_word_cnt <= '0;
      r_byte_idx <= 2'd0;
    end else if (w_accept) begin
      case (r_state)
        LEN_LO: r_len_lo <= byte_data;
        LEN_HI: r_len_hi <= byte_data;
        DATA: begin
          if (r_byte_idx == 2'd3) begin
            r_byte_idx <= 2'd0;
            r_word_cnt <= r_word_cnt + 1'b1;
          end else begin
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        default: begin
          r_byte_idx <= r_byte_idx;
        end
      endcase
    end
  end

  // Assemble the low three bytes of the word in flight; the fourth goes straight to RAM.
  always_ff @(posedge clk) begin
    if (w_in_data) begin
      case (r_byte_idx)
        2'd0:    r_asm[7:0]   <= byte_data;
        2'd1:    r_asm[15:8]  <= byte_data;
        2'd2:    r_asm[23:16] <= byte_data;
        default: r_asm        <= r_asm;
      endcase
    end
  end

  // Instruction RAM write port; contents survive reset and are not cleared between loads.
  always_ff @(posedge clk) begin
    if (w_word_done) begin
      r_mem[r_word_cnt[ADDR_W-1:0]] <= {byte_data, r_asm};
    end
  end

endmodule

// File: tb/tb_cpu_imem_loader.sv
// Scoreboard bench for cpu_imem_loader: the stimulus queues expected load completions
// and signal probes; a monitor on the falling clock edge pops and compares them.
module tb_cpu_imem_loader;

  localparam int          ADDR_W = 12;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_start;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic            running;
  logic [15:0]     pc;
  logic [31:0]     pc_instr;
  logic            load_err;
  logic [ADDR_W:0] word_cnt;

  typedef enum int {K_INSTR, K_CNT, K_RUN, K_ERR, K_RDY} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] exp;
  } chk_t;
  typedef struct {
    string name;
    bit    run;
    bit    err;
    int    cnt;
    int    at;
  } evt_t;

  chk_t       q_chk[$];
  evt_t       q_evt[$];
  logic [7:0] bq[$];
  int         n_chk   = 0;
  int         n_fail  = 0;
  int         neg_cnt = 0;
  logic       probe   = 1'b0;

  cpu_imem_loader #(.ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .running    (running),
    .pc         (pc),
    .pc_instr   (pc_instr),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: completion events on rising running/load_err, probes when strobed.
  initial begin : monitor
    bit          prev_run;
    bit          prev_err;
    chk_t        c;
    evt_t        e;
    logic [31:0] act;
    prev_run = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if ((running === 1'b1 && !prev_run) || (load_err === 1'b1 && !prev_err)) begin
        n_chk++;
        if (q_evt.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: running=%0b load_err=%0b word_cnt=%0d, none expected",
                   running, load_err, word_cnt);
        end else begin
          e = q_evt.pop_front();
          if (running !== e.run || load_err !== e.err || int'(word_cnt) != e.cnt || neg_cnt != e.at) begin
            n_fail++;
            $display("FAIL %s: got running=%0b load_err=%0b word_cnt=%0d cycle=%0d, expected %0b %0b %0d %0d",
                     e.name, running, load_err, word_cnt, neg_cnt, e.run, e.err, e.cnt, e.at);
          end
        end
      end
      if (probe) begin
        while (q_chk.size() > 0) begin
          c = q_chk.pop_front();
          case (c.kind)
            K_INSTR: act = pc_instr;
            K_CNT:   act = 32'(word_cnt);
            K_RUN:   act = {31'd0, running};
            K_ERR:   act = {31'd0, load_err};
            default: act = {31'd0, byte_ready};
          endcase
          n_chk++;
          if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", c.name, act, c.exp);
          end
        end
      end
      prev_run = (running === 1'b1);
      prev_err = (load_err === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic check(input string name, input kind_t k, input logic [31:0] exp, input logic [15:0] pcv);
    chk_t c;
    pc     = pcv;
    c.name = name;
    c.kind = k;
    c.exp  = exp;
    q_chk.push_back(c);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  // Send the bytes in bq; optionally expect a completion event on the last one.
  task automatic send_seq(input bit gap, input bit done, input string name,
                          input bit run, input bit err, input int cnt);
    evt_t e;
    int   n;
    for (int i = 0; i < bq.size(); i++) begin
      if (gap) begin
        byte_valid = 1'b0;
        tick();
      end
      byte_valid = 1'b1;
      byte_data  = bq[i];
      n = 0;
      while (byte_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (byte_ready !== 1'b1) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_ready_timeout: byte_ready=%0b, expected 1", name, byte_ready);
        byte_valid = 1'b0;
        return;
      end
      if (done && i == bq.size() - 1) begin
        e.name = name;
        e.run  = run;
        e.err  = err;
        e.cnt  = cnt;
        e.at   = neg_cnt + 1;
        q_evt.push_back(e);
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  initial begin : stimulus
    rst_n      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    pc         = 16'h0000;

    // Reset state
    check("rst_running", K_RUN,   32'd0, 16'h0004);
    check("rst_err",     K_ERR,   32'd0, 16'h0004);
    check("rst_ready",   K_RDY,   32'd0, 16'h0004);
    check("rst_cnt",     K_CNT,   32'd0, 16'h0004);
    check("rst_instr",   K_INSTR, NOP,   16'h0004);
    rst_n = 1'b1;
    tick();
    check("idle_ready",  K_RDY,   32'd0, 16'h0000);

    // Normal two-word load
    pulse_start();
    bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    send_seq(1'b0, 1'b1, "load2_done", 1'b1, 1'b0, 2);
    check("load2_pc4",   K_INSTR, 32'h0020_0113, 16'h0004);
    check("load2_pc0",   K_INSTR, 32'h0010_0093, 16'h0000);
    check("load2_pc6",   K_INSTR, 32'h0020_0113, 16'h0006);
    check("load2_cnt",   K_CNT,   32'd2,         16'h0004);
    check("run_ready",   K_RDY,   32'd0,         16'h0004);
    check("pc_oor_nop",  K_INSTR, NOP,           16'h4000);

    // Reload from RUN with backpressure on every other cycle
    pulse_start();
    check("reload_run_drop", K_RUN,   32'd0, 16'h0004);
    check("reload_nop",      K_INSTR, NOP,   16'h0004);
    send_seq(1'b1, 1'b1, "bp_done", 1'b1, 1'b0, 2);
    check("bp_pc0",      K_INSTR, 32'h0010_0093, 16'h0000);
    check("bp_pc4",      K_INSTR, 32'h0020_0113, 16'h0004);

    // Bad headers: N=0 and N=4097
    pulse_start();
    bq = '{8'h00, 8'h00};
    send_seq(1'b0, 1'b1, "hdr_zero", 1'b0, 1'b1, 0);
    check("err_flag",    K_ERR,   32'd1, 16'h0004);
    check("err_running", K_RUN,   32'd0, 16'h0004);
    check("err_nop",     K_INSTR, NOP,   16'h0004);
    check("err_ready",   K_RDY,   32'd0, 16'h0004);
    pulse_start();
    check("err_cleared", K_ERR,   32'd0, 16'h0004);
    bq = '{8'h01, 8'h10};
    send_seq(1'b0, 1'b1, "hdr_4097", 1'b0, 1'b1, 0);
    // N=4096 is the largest legal count: enters DATA
    pulse_start();
    bq = '{8'h00, 8'h10};
    send_seq(1'b0, 1'b0, "hdr_4096", 1'b0, 1'b0, 0);
    check("hdr_4096_ready", K_RDY, 32'd1, 16'h0000);
    check("hdr_4096_err",   K_ERR, 32'd0, 16'h0000);

    // Abort after 1.5 words, byte colliding with load_start is discarded
    pulse_start();
    bq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_seq(1'b0, 1'b0, "abort_part", 1'b0, 1'b0, 0);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    tick();
    load_start = 1'b0;
    byte_valid = 1'b0;
    bq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(1'b0, 1'b1, "abort_reload", 1'b1, 1'b0, 1);
    check("abort_pc0",   K_INSTR, 32'hDEAD_BEEF, 16'h0000);
    check("abort_keep1", K_INSTR, 32'h0020_0113, 16'h0004);
    check("abort_cnt",   K_CNT,   32'd1,         16'h0000);

    // Reload from RUN: NOP until the new load completes
    pulse_start();
    check("rerun_drop",  K_RUN,   32'd0, 16'h0000);
    check("rerun_nop",   K_INSTR, NOP,   16'h0000);
    bq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_seq(1'b0, 1'b1, "rerun_done", 1'b1, 1'b0, 1);
    check("rerun_pc0",   K_INSTR, 32'h1234_5678, 16'h0000);
    check("rerun_pc3",   K_INSTR, 32'h1234_5678, 16'h0003);

    // Reset in the middle of word 1
    pulse_start();
    bq = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    send_seq(1'b0, 1'b0, "rst_mid", 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    check("rstmid_running", K_RUN,   32'd0, 16'h0000);
    check("rstmid_cnt",     K_CNT,   32'd0, 16'h0000);
    check("rstmid_err",     K_ERR,   32'd0, 16'h0000);
    check("rstmid_ready",   K_RDY,   32'd0, 16'h0000);
    check("rstmid_nop",     K_INSTR, NOP,   16'h0000);
    rst_n = 1'b1;
    tick();
    pulse_start();
    bq = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(1'b0, 1'b1, "rstmid_reload", 1'b1, 1'b0, 1);
    check("rstmid_keep1",   K_INSTR, 32'h0020_0113, 16'h0004);
    check("rstmid_pc0",     K_INSTR, 32'hDEAD_BEEF, 16'h0000);

    tick();
    tick();
    n_chk++;
    if (q_evt.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d completions pending, expected 0", q_evt.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
